mips_fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS datapath. It sits directly upstream of the instruction parser.
- Owns the program counter and runs a req/ack handshake with instruction memory.
- Presents an IF/ID register (instruction, p_count, valid) that the parser consumes.
- Applies stall and redirect (branch/jump/jr) requests from decode/execute.

---
 rtl/mips_fetch_pkg.sv | 25 ++
 rtl/mips_target_calc.sv | 29 ++
 rtl/mips_fetch_stage.sv | 143 ++++++++++++++
 tb/tb_mips_fetch_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  SEL_BRANCH = 2'b00;
  localparam logic [1:0]  SEL_JUMP   = 2'b01;
  localparam logic [1:0]  SEL_JR     = 2'b10;
  localparam logic [1:0]  SEL_RSVD   = 2'b11;  // decoded as jr

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] PC_INC     = 32'd4;

  // One IF/ID-shaped entry: used for the stall hold buffer.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

endpackage

// File: rtl/mips_target_calc.sv
// Combinational redirect target: branch, jump, jr (reserved sel acts as jr).
module mips_target_calc
  import mips_fetch_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] base,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic [31:0] reg_val,
  output logic [31:0] target
);

  logic [31:0] base4;
  logic [31:0] br_off;

  assign base4  = base + PC_INC;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Select the target; all adds wrap mod 2^32, jr keeps its low bits as-is.
  always_comb begin
    target = reg_val;
    unique case (sel)
      SEL_BRANCH: target = base4 + br_off;
      SEL_JUMP:   target = {base4[31:28], addr26, 2'b00};
      default:    target = reg_val;
    endcase
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS fetch stage: PC, imem req/ack handshake, stall buffer, redirect drain.
module mips_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_sel,
  input  logic [31:0]       redirect_base,
  input  logic [15:0]       redirect_imm16,
  input  logic [25:0]       redirect_addr26,
  input  logic [31:0]       redirect_reg,
  output logic [31:0]       instruction,
  output logic [31:0]       p_count,
  output logic              if_valid
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  pend, pend_n;
  ifid_t        hbuf, hbuf_n;
  logic [31:0]  instr_n, pcnt_n;
  logic         vld_n;
  logic [31:0]  target;
  logic         xfer;

  mips_target_calc u_tgt (
    .sel     (redirect_sel),
    .base    (redirect_base),
    .imm16   (redirect_imm16),
    .addr26  (redirect_addr26),
    .reg_val (redirect_reg),
    .target  (target)
  );

  // Address is the live PC; PC only moves on a transfer or redirect, so it
  // stays stable while a request waits for ack.
  assign imem_addr = pc[ADDR_W-1:0];
  assign xfer      = imem_req & imem_ack;

  // State register plus all fetch-side registers, async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      pend        <= '0;
      hbuf        <= '0;
      instruction <= NOP_INSTR;
      p_count     <= '0;
      if_valid    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend        <= pend_n;
      hbuf        <= hbuf_n;
      instruction <= instr_n;
      p_count     <= pcnt_n;
      if_valid    <= vld_n;
    end
  end

  // Next-state and datapath control; redirect outranks stall in every state.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    pend_n   = pend;
    hbuf_n   = hbuf;
    instr_n  = instruction;
    pcnt_n   = p_count;
    vld_n    = if_valid;
    imem_req = (state == S_FETCH) || (state == S_DRAIN);

    if (redirect_valid) begin
      // Flush IF/ID and drop anything sitting in the hold buffer.
      vld_n   = 1'b0;
      instr_n = NOP_INSTR;
      hbuf_n  = '0;
      unique case (state)
        S_FETCH: begin
          if (xfer) pc_n = target;        // returned word is dropped
          else begin
            pend_n  = target;             // must finish the open request first
            state_n = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            pc_n    = target;
            state_n = S_FETCH;
          end else pend_n = target;       // newest redirect wins
        end
        default: begin                    // IDLE, HOLD: no request in flight
          pc_n    = target;
          state_n = S_FETCH;
        end
      endcase
    end else begin
      unique case (state)
        S_IDLE: state_n = S_FETCH;
        S_FETCH: begin
          if (xfer) begin
            pc_n = pc + PC_INC;
            if (stall) begin
              // Decode can't take it: park the word and stop requesting.
              hbuf_n  = '{instr: imem_rdata, pc: pc};
              state_n = S_HOLD;
            end else begin
              instr_n = imem_rdata;
              pcnt_n  = pc;
              vld_n   = 1'b1;
            end
          end else if (!stall) begin
            vld_n = 1'b0;                 // bubble while memory is busy
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_n = hbuf.instr;
            pcnt_n  = hbuf.pc;
            vld_n   = 1'b1;
            state_n = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            pc_n    = pend;               // stale word discarded
            state_n = S_FETCH;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: vector table plus async-reset sequence.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_base;
  logic [15:0] redirect_imm16;
  logic [25:0] redirect_addr26;
  logic [31:0] redirect_reg;
  logic [31:0] instruction;
  logic [31:0] p_count;
  logic        if_valid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Memory returns an address-tagged word so every fetch is identifiable.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  assign imem_rdata = tag(imem_addr);

  mips_fetch_stage #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_sel    (redirect_sel),
    .redirect_base   (redirect_base),
    .redirect_imm16  (redirect_imm16),
    .redirect_addr26 (redirect_addr26),
    .redirect_reg    (redirect_reg),
    .instruction     (instruction),
    .p_count         (p_count),
    .if_valid        (if_valid)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [1:0]  sel;
    logic [31:0] base;
    logic [15:0] imm;
    logic [25:0] a26;
    logic [31:0] rreg;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string pfx, input logic e_req, input logic [31:0] e_addr,
                         input logic e_vld, input logic [31:0] e_instr, input logic [31:0] e_pc);
    chk({pfx, " req"},   {31'b0, imem_req}, {31'b0, e_req});
    chk({pfx, " addr"},  imem_addr, e_addr);
    chk({pfx, " valid"}, {31'b0, if_valid}, {31'b0, e_vld});
    chk({pfx, " instr"}, instruction, e_instr);
    chk({pfx, " pcnt"},  p_count, e_pc);
  endtask

  // Plain (no redirect) row.
  task automatic vn(input logic st, input logic ack, input logic rq, input logic [31:0] ad,
                    input logic vl, input logic [31:0] ins, input logic [31:0] pcn);
    vq.push_back('{st, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0, ack, rq, ad, vl, ins, pcn});
  endtask

  // Redirect row.
  task automatic vr(input logic [1:0] sel, input logic [31:0] base, input logic [15:0] imm,
                    input logic [25:0] a26, input logic [31:0] rreg, input logic st, input logic ack,
                    input logic rq, input logic [31:0] ad, input logic vl,
                    input logic [31:0] ins, input logic [31:0] pcn);
    vq.push_back('{st, 1'b1, sel, base, imm, a26, rreg, ack, rq, ad, vl, ins, pcn});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_sel = 2'b00; redirect_base = '0; redirect_imm16 = '0;
    redirect_addr26 = '0; redirect_reg = '0;

    //  stall ack | req addr          valid instr              p_count
    vn(0, 1, 1, 32'h0,        0, 32'h0,              32'h0);         // IDLE -> FETCH
    vn(0, 1, 1, 32'h4,        1, tag(32'h0),         32'h0);
    vn(0, 1, 1, 32'h8,        1, tag(32'h4),         32'h4);
    vn(0, 1, 1, 32'hC,        1, tag(32'h8),         32'h8);
    vn(1, 1, 0, 32'h10,       1, tag(32'h8),         32'h8);         // word C buffered
    vn(1, 1, 0, 32'h10,       1, tag(32'h8),         32'h8);
    vn(1, 1, 0, 32'h10,       1, tag(32'h8),         32'h8);
    vn(0, 1, 1, 32'h10,       1, tag(32'hC),         32'hC);         // buffer released
    vn(0, 1, 1, 32'h14,       1, tag(32'h10),        32'h10);
    vr(2'b00, 32'h40, 16'hFFFE, 26'h0, 32'h0, 0, 1,
       1, 32'h3C,             0, 32'h0,              32'h10);        // branch
    vn(0, 1, 1, 32'h40,       1, tag(32'h3C),        32'h3C);
    vr(2'b01, 32'hA000_0010, 16'h0, 26'h0000100, 32'h0, 0, 1,
       1, 32'hA000_0400,      0, 32'h0,              32'h3C);        // jump
    vn(0, 1, 1, 32'hA000_0404, 1, tag(32'hA000_0400), 32'hA000_0400);
    vr(2'b10, 32'h0, 16'h0, 26'h0, 32'h1234_5678, 0, 1,
       1, 32'h1234_5678,      0, 32'h0,              32'hA000_0400); // jr
    vr(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_0100, 0, 1,
       1, 32'h100,            0, 32'h0,              32'hA000_0400); // reserved = jr
    vn(0, 0, 1, 32'h100,      0, 32'h0,              32'hA000_0400); // wait, bubble
    vn(0, 1, 1, 32'h104,      1, tag(32'h100),       32'h100);
    vn(0, 0, 1, 32'h104,      0, tag(32'h100),       32'h100);       // ack delay 1
    vr(2'b00, 32'h200, 16'h0010, 26'h0, 32'h0, 0, 0,
       1, 32'h104,            0, 32'h0,              32'h100);       // -> DRAIN, tgt 244
    vn(0, 0, 1, 32'h104,      0, 32'h0,              32'h100);
    vn(0, 1, 1, 32'h244,      0, 32'h0,              32'h100);       // drained, stale dropped
    vn(0, 1, 1, 32'h248,      1, tag(32'h244),       32'h244);
    vn(0, 0, 1, 32'h248,      0, tag(32'h244),       32'h244);
    vr(2'b10, 32'h0, 16'h0, 26'h0, 32'h800, 0, 0,
       1, 32'h248,            0, 32'h0,              32'h244);       // DRAIN tgt 800
    vr(2'b10, 32'h0, 16'h0, 26'h0, 32'h900, 0, 0,
       1, 32'h248,            0, 32'h0,              32'h244);       // overwrite -> 900
    vn(0, 1, 1, 32'h900,      0, 32'h0,              32'h244);
    vn(0, 1, 1, 32'h904,      1, tag(32'h900),       32'h900);
    vn(1, 0, 1, 32'h904,      1, tag(32'h900),       32'h900);       // stall, no xfer
    vn(1, 1, 0, 32'h908,      1, tag(32'h900),       32'h900);       // -> HOLD
    vr(2'b10, 32'h0, 16'h0, 26'h0, 32'h40, 1, 0,
       1, 32'h40,             0, 32'h0,              32'h900);       // redirect beats stall
    vn(0, 1, 1, 32'h44,       1, tag(32'h40),        32'h40);        // buffer discarded
    vn(0, 0, 1, 32'h44,       0, tag(32'h40),        32'h40);
    vn(1, 1, 0, 32'h48,       0, tag(32'h40),        32'h40);        // no bubble collapse
    vn(0, 0, 1, 32'h48,       1, tag(32'h44),        32'h44);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk("idle req", {31'b0, imem_req}, 32'h0);

    foreach (vq[i]) begin
      stall           = vq[i].stall;
      redirect_valid  = vq[i].rv;
      redirect_sel    = vq[i].sel;
      redirect_base   = vq[i].base;
      redirect_imm16  = vq[i].imm;
      redirect_addr26 = vq[i].a26;
      redirect_reg    = vq[i].rreg;
      imem_ack        = vq[i].ack;
      tick();
      chk_all($sformatf("row%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_vld,
              vq[i].e_instr, vq[i].e_pc);
    end

    // Async reset in the middle of an outstanding request, between edges.
    stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    imem_ack = 1'b1;
    tick();
    chk_all("rst_idle", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk_all("rst_fetch", 1'b1, 32'h4, 1'b1, tag(32'h0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
